// File: rtl/jio_ctrl.sv
// I/O controller between the CU strobes / wired-OR bus and NDEV device channels.
// Holds the selected device, a TX FIFO and an RX holding register per channel, and a status word.
module jio_ctrl #(
  parameter int WIDTH = 8,
  parameter int NDEV  = 4,
  parameter int DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  reset_n,
  input  logic [WIDTH-1:0]      bus_in,
  input  logic                  io_s,
  input  logic                  io_e,
  input  logic                  io_da,
  input  logic                  io_io,
  output logic [WIDTH-1:0]      bus_out,
  output logic [NDEV*WIDTH-1:0] tx_data,
  output logic [NDEV-1:0]       tx_valid,
  input  logic [NDEV-1:0]       tx_ready,
  input  logic [NDEV*WIDTH-1:0] rx_data,
  input  logic [NDEV-1:0]       rx_valid,
  output logic [NDEV-1:0]       rx_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

  logic [WIDTH-1:0] dev_sel;
  logic             io_s_q, rd_data_q, rd_stat_q, ovf;
  logic [PW:0]      wr_ptr [NDEV];
  logic [PW:0]      rd_ptr [NDEV];
  logic [WIDTH-1:0] mem    [NDEV][DEPTH];
  logic [WIDTH-1:0] hold   [NDEV];
  logic [NDEV-1:0]  held, empty, full, sel_hit, push, pop;
  logic             cmd_edge, addr_cmd, data_cmd, data_done, stat_done, drop_full;

  assign cmd_edge  = io_s & ~io_s_q;
  assign addr_cmd  = cmd_edge & io_da & io_io;
  assign data_cmd  = cmd_edge & ~io_da & io_io;
  // Read completion is the falling edge of io_e, using the decode registered while it was high.
  assign data_done = rd_data_q & ~io_e;
  assign stat_done = rd_stat_q & ~io_e;
  assign drop_full = data_cmd & |(sel_hit & full);

  assign tx_valid = ~empty;
  assign rx_ready = ~held & {NDEV{reset_n}};

  always_comb begin
    empty   = '0;
    full    = '0;
    sel_hit = '0;
    push    = '0;
    pop     = '0;
    tx_data = '0;
    for (int unsigned k = 0; k < NDEV; k++) begin
      empty[k]   = (wr_ptr[k] == rd_ptr[k]);
      full[k]    = (wr_ptr[k][PW] != rd_ptr[k][PW]) && (wr_ptr[k][PW-1:0] == rd_ptr[k][PW-1:0]);
      sel_hit[k] = (dev_sel == WIDTH'(k));
      push[k]    = data_cmd & sel_hit[k] & ~full[k];
      pop[k]     = ~empty[k] & tx_ready[k];
      tx_data[k*WIDTH +: WIDTH] = mem[k][rd_ptr[k][PW-1:0]];
    end
  end

  always_comb begin
    bus_out = '0;
    if (reset_n && io_e && !io_io) begin
      // Null device: data reads 0, status reads "empty".
      if (io_da) bus_out = WIDTH'(4'b0010);
      for (int unsigned k = 0; k < NDEV; k++) begin
        if (sel_hit[k]) begin
          if (io_da) bus_out = WIDTH'({ovf, held[k], empty[k], full[k]});
          else       bus_out = held[k] ? hold[k] : '0;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      dev_sel   <= '0;
      io_s_q    <= 1'b0;
      rd_data_q <= 1'b0;
      rd_stat_q <= 1'b0;
      ovf       <= 1'b0;
      held      <= '0;
      for (int unsigned k = 0; k < NDEV; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        hold[k]   <= '0;
      end
    end else begin
      io_s_q    <= io_s;
      rd_data_q <= io_e & ~io_io & ~io_da;
      rd_stat_q <= io_e & ~io_io & io_da;
      if (addr_cmd)  dev_sel <= bus_in;
      if (stat_done) ovf <= 1'b0;
      if (drop_full) ovf <= 1'b1;
      for (int unsigned k = 0; k < NDEV; k++) begin
        if (push[k]) wr_ptr[k] <= wr_ptr[k] + PTR_ONE;
        if (pop[k])  rd_ptr[k] <= rd_ptr[k] + PTR_ONE;
        // A consuming read wins over a load; rx_ready is low in that cycle anyway.
        if (data_done && sel_hit[k] && held[k]) begin
          held[k] <= 1'b0;
        end else if (rx_valid[k] && !held[k]) begin
          held[k] <= 1'b1;
          hold[k] <= rx_data[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int unsigned k = 0; k < NDEV; k++) begin
      if (push[k]) mem[k][wr_ptr[k][PW-1:0]] <= bus_in;
    end
  end

endmodule

// File: tb/tb_jio_ctrl.sv
// Directed bench for jio_ctrl: command/read vector table plus hand-written multi-cycle sequences.
module tb_jio_ctrl;
  localparam int WIDTH = 8;
  localparam int NDEV  = 4;
  localparam int DEPTH = 4;

  logic                  CLK, reset_n;
  logic [WIDTH-1:0]      bus_in, bus_out;
  logic                  io_s, io_e, io_da, io_io;
  logic [NDEV*WIDTH-1:0] tx_data, rx_data;
  logic [NDEV-1:0]       tx_valid, tx_ready, rx_valid, rx_ready;

  jio_ctrl #(.WIDTH(WIDTH), .NDEV(NDEV), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .reset_n(reset_n), .bus_in(bus_in),
    .io_s(io_s), .io_e(io_e), .io_da(io_da), .io_io(io_io),
    .bus_out(bus_out), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef enum {OP_ADDR, OP_PUSH, OP_RDD, OP_RDS} op_e;
  typedef struct {
    op_e        op;
    logic [7:0] val;
    logic [7:0] exp;
  } vec_t;

  vec_t       tbl [16];
  int         checks = 0;
  int         failures = 0;
  bit         alt_rdy = 0;
  bit         mon_en = 0;
  int         pops = 0;
  logic [7:0] exp_q [$];
  logic [7:0] r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    if (alt_rdy) tx_ready[3] = ~tx_ready[3];
  endtask

  task automatic cmd(input logic da, input logic [7:0] val);
    bus_in = val; io_da = da; io_io = 1'b1; io_s = 1'b1;
    step();
    io_s = 1'b0;
    step();
    io_io = 1'b0; io_da = 1'b0;
  endtask

  task automatic rd(input logic da, output logic [7:0] v);
    io_io = 1'b0; io_da = da; io_e = 1'b1;
    #1 v = bus_out;
    step();
    io_e = 1'b0;
    step();
    io_da = 1'b0;
  endtask

  task automatic run_tbl(input int lo, input int hi);
    logic [7:0] v;
    for (int i = lo; i <= hi; i++) begin
      case (tbl[i].op)
        OP_ADDR: cmd(1'b1, tbl[i].val);
        OP_PUSH: cmd(1'b0, tbl[i].val);
        OP_RDD:  begin rd(1'b0, v); chk($sformatf("vec%0d_data", i), v, tbl[i].exp); end
        default: begin rd(1'b1, v); chk($sformatf("vec%0d_status", i), v, tbl[i].exp); end
      endcase
    end
  endtask

  // Every pop seen on channel 3 must match the oldest word pushed there.
  always @(negedge CLK) begin
    if (mon_en && tx_valid[3] && tx_ready[3]) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wrap_extra_pop: got %0h expected none", tx_data[3*WIDTH +: WIDTH]);
      end else begin
        chk("wrap_order", tx_data[3*WIDTH +: WIDTH], exp_q.pop_front());
        pops++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{OP_ADDR, 8'h02, 8'h00};
    tbl[1]  = '{OP_PUSH, 8'h41, 8'h00};
    tbl[2]  = '{OP_PUSH, 8'h42, 8'h00};
    tbl[3]  = '{OP_PUSH, 8'h43, 8'h00};
    tbl[4]  = '{OP_PUSH, 8'h44, 8'h00};
    tbl[5]  = '{OP_PUSH, 8'h45, 8'h00};
    tbl[6]  = '{OP_RDS,  8'h00, 8'h09};
    tbl[7]  = '{OP_RDS,  8'h00, 8'h02};
    tbl[8]  = '{OP_ADDR, 8'h01, 8'h00};
    tbl[9]  = '{OP_RDS,  8'h00, 8'h06};
    tbl[10] = '{OP_RDD,  8'h00, 8'hA5};
    tbl[11] = '{OP_RDD,  8'h00, 8'h00};
    tbl[12] = '{OP_ADDR, 8'hFF, 8'h00};
    tbl[13] = '{OP_PUSH, 8'h77, 8'h00};
    tbl[14] = '{OP_RDD,  8'h00, 8'h00};
    tbl[15] = '{OP_RDS,  8'h00, 8'h02};

    // Reset with random inputs
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_in = WIDTH'($urandom); io_s = 1'($urandom); io_e = 1'($urandom);
      io_da = 1'($urandom); io_io = 1'($urandom);
      tx_ready = NDEV'($urandom); rx_valid = NDEV'($urandom); rx_data = $urandom;
      #1;
      chk("rst_bus_out", bus_out, 0);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_rx_ready", rx_ready, 0);
      step();
    end
    io_s = 0; io_e = 0; io_da = 0; io_io = 0; bus_in = '0;
    tx_ready = '0; rx_valid = '0; rx_data = '0;
    reset_n = 1'b1;
    #1 chk("rel_rx_ready", rx_ready, 4'hF);
    step();
    rd(1'b1, r);
    chk("rel_status_dev0", r, 8'h02);

    // Fill dev 2 past full, then drain in order
    run_tbl(0, 5);
    chk("full_tx_valid2", tx_valid[2], 1'b1);
    chk("full_head", tx_data[2*WIDTH +: WIDTH], 8'h41);
    run_tbl(6, 6);
    tx_ready[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d", i), tx_data[2*WIDTH +: WIDTH], 8'h41 + 8'(i));
      step();
    end
    tx_ready[2] = 1'b0;
    chk("drained_tx_valid", tx_valid, 0);
    run_tbl(7, 7);

    // io_s held high: exactly one push
    bus_in = 8'h66; io_da = 1'b0; io_io = 1'b1; io_s = 1'b1;
    repeat (10) step();
    io_s = 1'b0; io_io = 1'b0;
    step();
    chk("hold_one_valid", tx_valid[2], 1'b1);
    tx_ready[2] = 1'b1;
    chk("hold_one_data", tx_data[2*WIDTH +: WIDTH], 8'h66);
    step();
    tx_ready[2] = 1'b0;
    chk("hold_one_empty", tx_valid[2], 1'b0);

    // RX hold and consuming read
    rx_data[1*WIDTH +: WIDTH] = 8'hA5; rx_valid[1] = 1'b1;
    step();
    chk("rx_ready_drop", rx_ready[1], 1'b0);
    rx_valid[1] = 1'b0; rx_data[1*WIDTH +: WIDTH] = 8'h5A;
    run_tbl(8, 10);
    chk("rx_ready_back", rx_ready[1], 1'b1);
    run_tbl(11, 11);

    // FIFO wrap on dev 3 with alternating tx_ready
    cmd(1'b1, 8'h03);
    tx_ready[3] = 1'b0; mon_en = 1; alt_rdy = 1;
    for (int i = 0; i < 3*DEPTH+1; i++) begin
      exp_q.push_back(8'h80 + 8'(i));
      cmd(1'b0, 8'h80 + 8'(i));
    end
    alt_rdy = 0; tx_ready[3] = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    step();
    mon_en = 0; tx_ready[3] = 1'b0;
    chk("wrap_pops", pops, 3*DEPTH+1);
    chk("wrap_left", exp_q.size(), 0);
    rd(1'b1, r);
    chk("wrap_status", r, 8'h02);

    // Null device
    run_tbl(12, 15);
    chk("null_tx_valid", tx_valid, 0);

    // Reset mid-burst
    cmd(1'b1, 8'h02);
    cmd(1'b0, 8'h11);
    cmd(1'b0, 8'h22);
    chk("burst_valid", tx_valid[2], 1'b1);
    bus_in = 8'h33; io_io = 1'b1; io_s = 1'b1;
    #1 reset_n = 1'b0;
    #1 chk("midrst_tx_valid", tx_valid, 0);
    step();
    io_s = 1'b0; io_io = 1'b0;
    reset_n = 1'b1;
    step();
    cmd(1'b0, 8'h55);
    chk("midrst_devsel0", tx_valid, 4'b0001);
    chk("midrst_data", tx_data[0 +: WIDTH], 8'h55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
